load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: DMEM_WORDS, 1024, data-memory depth in 32-bit words; byte addresses >= DMEM_WORDS*4 are out of range.
REQ-002 SHALL have ports (name direction width meaning), in this order:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- lsu_valid_i  in  1  core presents an operation.
- lsu_ready_o  out  1  LSU can accept an operation.
- lsu_op_i  in  2  00 none, 01 load, 10 store, 11 reserved.
- lsu_size_i  in  2  BYTE 00, HALF_WORD 01, WORD 10, 11 reserved.
- lsu_unsigned_i  in  1  load zero-extends when 1.
- lsu_base_i  in  32  rs1 value.
- lsu_offset_i  in  12  signed immediate.
- lsu_store_data_i  in  32  rs2 value.
- lsu_rd_i  in  5  load destination register.
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_wb_en_o  out  1  load result valid for writeback, with done.
- lsu_rd_o  out  5  destination register, with done.
- lsu_load_data_o  out  32  extended load result.
- lsu_err_o  out  1  access fault, with done.
- lsu_err_addr_o  out  32  faulting effective address.
- data_mem_req_o  out  1  memory request.
- data_mem_addr_o  out  32  byte address.
- data_mem_byte_en_o  out  2  access size, same encoding as lsu_size_i.
- data_mem_wr_o  out  1  write when 1.
- data_mem_wr_data_o  out  32  store data, right-aligned.
- data_mem_zero_extnd_o  out  1  unsigned load.
- data_mem_rd_data_i  in  32  memory read data, valid the cycle after the request edge while addr/size held.

Function
REQ-003 SHALL compute the effective address as lsu_base_i + sign-extended lsu_offset_i, modulo 2^32, and register it with all operation fields on accept.
REQ-004 SHALL accept only when lsu_valid_i && lsu_ready_o; lsu_ready_o SHALL be 1 only in IDLE.
REQ-005 SHALL implement FSM states IDLE, REQ, RESP, DONE, ERR.
REQ-006 IDLE->REQ on accepted legal load/store; IDLE->ERR on accepted faulting op; IDLE->DONE on accepted op 00 or 11 (done=1, wb_en=0, err=0, no memory access).
REQ-007 REQ: data_mem_req_o=1 for exactly one cycle; store REQ->DONE, load REQ->RESP.
REQ-008 RESP: req=0, address/byte_en/zero_extnd held; load data register SHALL capture data_mem_rd_data_i at the end of RESP; RESP->DONE.
REQ-009 DONE: done=1 for one cycle; wb_en=1 and rd_o=registered rd only for loads; DONE->IDLE.
REQ-010 ERR: done=1, err=1, wb_en=0, err_addr=effective address for one cycle; ERR->IDLE; no memory request issued.
REQ-011 Faults: size 11; HALF_WORD with addr[0]=1; WORD with addr[1:0]!=0; addr >= DMEM_WORDS*4.
REQ-012 Latency from accept edge: store done in 2nd following cycle, load done in 3rd, fault/no-op done in 1st.
REQ-013 data_mem_* outputs SHALL be 0 in IDLE, DONE, ERR; data_mem_wr_o=1 only in REQ of a store.
REQ-014 lsu_load_data_o SHALL hold its last value until the next load completes.
REQ-015 lsu_valid_i while not ready SHALL be ignored; the core holds the operation.

Reset
REQ-016 reset_n low SHALL force IDLE and all outputs to 0 except lsu_ready_o=1, asynchronously, including mid-operation; an aborted operation SHALL produce no done pulse.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN: defined -> alignment faults per REQ-011; undefined -> addr low bits forced to 0 (bit 0 for HALF_WORD, bits 1:0 for WORD) and access proceeds; size-11 and range faults remain.

Verification
REQ-018 Store WORD base 0x10 offset 4 data 0xDEADBEEF -> one req cycle, addr 0x14, wr=1, done 2 cycles after accept, wb_en=0.
REQ-019 Then load WORD addr 0x14 rd=5 -> done 3 cycles after accept, load_data 0xDEADBEEF, rd_o=5, wb_en=1.
REQ-020 Load BYTE signed addr 0x17 after REQ-018 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-021 Load WORD base 0x22 offset -1 (0x21), macro defined -> err=1, err_addr 0x21, no req; macro undefined -> addr 0x20 accessed.
REQ-022 Load addr DMEM_WORDS*4 -> err=1, no req; reset_n pulsed during RESP of a load -> IDLE, ready=1, no done.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one memory operation at a time, IDLE/REQ/RESP/DONE/ERR FSM.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses instead of aligning.
module load_store_unit #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [1:0]  lsu_op_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_base_i,
  input  logic [11:0] lsu_offset_i,
  input  logic [31:0] lsu_store_data_i,
  input  logic [4:0]  lsu_rd_i,
  output logic        lsu_done_o,
  output logic        lsu_wb_en_o,
  output logic [4:0]  lsu_rd_o,
  output logic [31:0] lsu_load_data_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_err_addr_o,
  output logic        data_mem_req_o,
  output logic [31:0] data_mem_addr_o,
  output logic [1:0]  data_mem_byte_en_o,
  output logic        data_mem_wr_o,
  output logic [31:0] data_mem_wr_data_o,
  output logic        data_mem_zero_extnd_o,
  input  logic [31:0] data_mem_rd_data_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [32:0] LIMIT = 33'(DMEM_WORDS) * 33'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] ea_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        load_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] ldata_q, ldata_d;

  logic [31:0] ea;
  logic [31:0] ea_eff;
  logic        is_mem;
  logic        mis_h;
  logic        mis_w;
  logic        oor;
  logic        fault;
  logic        accept;
  logic [31:0] wdata_m;

  function automatic logic [31:0] ext(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic        u
  );
    logic [31:0] r;
    r = d;
    if (sz == SZ_B)
      r = {{24{d[7] & ~u}}, d[7:0]};
    else if (sz == SZ_H)
      r = {{16{d[15] & ~u}}, d[15:0]};
    return r;
  endfunction

  assign ea = lsu_base_i
            + {{20{lsu_offset_i[11]}}, lsu_offset_i};

  assign is_mem = (lsu_op_i == OP_LOAD)
               || (lsu_op_i == OP_STORE);
  assign mis_h  = (lsu_size_i == SZ_H) && ea[0];
  assign mis_w  = (lsu_size_i == SZ_W)
               && (ea[1:0] != 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
  assign ea_eff = ea;
  assign fault  = (lsu_size_i == SZ_X) || mis_h
               || mis_w || oor;
`else
  always_comb begin
    ea_eff = ea;
    if (mis_h)
      ea_eff[0] = 1'b0;
    if (mis_w)
      ea_eff[1:0] = 2'b00;
  end
  assign fault = (lsu_size_i == SZ_X) || oor;
`endif

  assign oor    = ({1'b0, ea_eff} >= LIMIT);
  assign accept = lsu_valid_i && (state_q == S_IDLE);

  always_comb begin
    wdata_m = lsu_store_data_i;
    if (lsu_size_i == SZ_B)
      wdata_m = {24'h0, lsu_store_data_i[7:0]};
    else if (lsu_size_i == SZ_H)
      wdata_m = {16'h0, lsu_store_data_i[15:0]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem)
            state_d = S_DONE;
          else if (fault)
            state_d = S_ERR;
          else
            state_d = S_REQ;
        end
      end
      S_REQ:   state_d = load_q ? S_RESP : S_DONE;
      S_RESP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load result is extended here so memory may return raw right-aligned data
  always_comb begin
    ldata_d = ldata_q;
    if (state_q == S_RESP)
      ldata_d = ext(data_mem_rd_data_i, size_q, uns_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ea_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      ldata_q <= ldata_d;
      if (accept) begin
        ea_q    <= ea;
        addr_q  <= ea_eff;
        size_q  <= lsu_size_i;
        uns_q   <= lsu_unsigned_i;
        load_q  <= (lsu_op_i == OP_LOAD);
        wdata_q <= wdata_m;
        rd_q    <= lsu_rd_i;
      end
    end
  end

  logic in_req;
  logic in_acc;
  logic in_done;
  logic in_err;

  assign in_req  = (state_q == S_REQ);
  assign in_acc  = in_req || (state_q == S_RESP);
  assign in_done = (state_q == S_DONE);
  assign in_err  = (state_q == S_ERR);

  assign lsu_ready_o     = (state_q == S_IDLE);
  assign lsu_done_o      = in_done || in_err;
  assign lsu_wb_en_o     = in_done && load_q;
  assign lsu_rd_o        = (in_done && load_q) ? rd_q : 5'd0;
  assign lsu_load_data_o = ldata_q;
  assign lsu_err_o       = in_err;
  assign lsu_err_addr_o  = in_err ? ea_q : 32'd0;

  assign data_mem_req_o        = in_req;
  assign data_mem_addr_o       = in_acc ? addr_q : 32'd0;
  assign data_mem_byte_en_o    = in_acc ? size_q : 2'b00;
  assign data_mem_wr_o         = in_req && !load_q;
  assign data_mem_wr_data_o    = (in_req && !load_q)
                               ? wdata_q : 32'd0;
  assign data_mem_zero_extnd_o = in_acc && load_q && uns_q;

endmodule
